// File: rtl/hash_pkg.sv
// rtl/hash_pkg.sv - shared request layout, opcodes and sizing helpers for the hash-table request/response path
package hash_pkg;

  localparam int DEF_KEY_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH = 25;
  localparam int OP_WIDTH       = 2;
  localparam int OP_LSB         = DEF_KEY_WIDTH + DEF_DATA_WIDTH;
  localparam int KEY_LSB        = DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_NOP    = 2'd3
  } op_e;

  function automatic int calc_beats(input int req_width, input int in_width);
    return (req_width + in_width - 1) / in_width;
  endfunction

  function automatic int calc_keep(input int req_width);
    return (req_width + 7) / 8;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-entry stream output register holding data/last stable under back-pressure
module axis_out_reg
  import hash_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  // A new word may replace the current one in the same cycle it is taken.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_request_packer.sv
// rtl/axi_request_packer.sv - packs a narrow byte stream into {op, key, data} request words, dropping partial requests
module axi_request_packer
  import hash_pkg::*;
#(
  parameter int  KEY_WIDTH     = DEF_KEY_WIDTH,
  parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int  IN_WIDTH      = 8,
  parameter int  ERR_CNT_WIDTH = 16,
  localparam int REQ_WIDTH     = OP_WIDTH + KEY_WIDTH + DATA_WIDTH,
  localparam int BEATS         = calc_beats(REQ_WIDTH, IN_WIDTH),
  localparam int KEEP_WIDTH    = calc_keep(REQ_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_WIDTH-1:0]      s_data_i,
  input  logic                     s_valid_i,
  input  logic                     s_last_i,
  output logic                     s_ready_o,
  output logic [REQ_WIDTH-1:0]     m_data_o,
  output logic                     m_valid_o,
  output logic                     m_last_o,
  output logic [KEEP_WIDTH-1:0]    m_keep_o,
  input  logic                     m_ready_i,
  output logic                     err_pulse_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  localparam int ASM_WIDTH = BEATS * IN_WIDTH;
  localparam int CNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic [ASM_WIDTH-1:0] asm_q;
  logic [ASM_WIDTH-1:0] merged;
  logic                 out_can_load;
  logic                 accept;
  logic                 final_beat;
  logic                 partial;

  // Only the closing beat needs room in the output register; earlier beats overlap a stall.
  assign s_ready_o  = !((cnt == LAST_BEAT) && !out_can_load);
  assign accept     = s_valid_i && s_ready_o;
  assign final_beat = accept && (cnt == LAST_BEAT);
  assign partial    = accept && s_last_i && (cnt != LAST_BEAT);
  assign m_keep_o   = '1;

  always_comb begin
    merged = asm_q;
    merged[cnt*IN_WIDTH +: IN_WIDTH] = s_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      asm_q       <= '0;
      err_pulse_o <= 1'b0;
      err_count_o <= '0;
    end else begin
      err_pulse_o <= partial;
      if (partial && (err_count_o != {ERR_CNT_WIDTH{1'b1}})) begin
        err_count_o <= err_count_o + ERR_CNT_WIDTH'(1);
      end
      if (accept) begin
        if (final_beat || s_last_i) begin
          cnt   <= '0;
          asm_q <= '0;
        end else begin
          cnt   <= cnt + CNT_WIDTH'(1);
          asm_q <= merged;
        end
      end
    end
  end

  axis_out_reg #(
    .WIDTH(REQ_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .in_data  (merged[REQ_WIDTH-1:0]),
    .in_last  (s_last_i),
    .in_valid (final_beat),
    .in_ready (out_can_load),
    .out_data (m_data_o),
    .out_last (m_last_o),
    .out_valid(m_valid_o),
    .out_ready(m_ready_i)
  );

endmodule
